booth_mac_sequencer: RTL and testbench
======================================

# booth_mac_sequencer

Multiply-accumulate front/back end for the radix-2 Booth multiplier. Accepts signed operand pairs through a valid/ready stream and buffers them in a small FIFO. Issues one multiply at a time over the multiplier's start/Ready handshake and sign-extends each product into an accumulator. Emits one dot-product result per vector, where a vector ends at a pair tagged `i_last`.

## Interface
Parameters:
- `L_word`, 4: operand width; must match the multiplier.
- `L_DEPTH`, 4: operand FIFO depth, power of two, ≥2.
- `L_GUARD`, 4: accumulator guard bits; `L_ACC = 2*L_word + L_GUARD`.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset; one clock; reset is synchronous and active-low.
- `i_a`, `i_b` in `L_word`: signed operands.
- `i_last` in 1: marks the final pair of a vector.
- `i_valid` in 1: operand pair valid.
- `o_ready` out 1: FIFO not full.
- `o_mult_word1`, `o_mult_word2` out `L_word`: operands to the multiplier.
- `o_mult_start` out 1: one-cycle start pulse.
- `i_mult_product` in `2*L_word`: signed product.
- `i_mult_ready` in 1: multiplier idle, product valid.
- `i_mult_err` in 1: multiplier error.
- `o_acc` out `L_ACC`: signed dot-product result.
- `o_acc_valid` out 1: one-cycle result strobe.
- `o_err` out 1: one-cycle error strobe.
- `o_sat` out 1: saturation flag; qualified by `o_acc_valid`.

## Operation
- **Push:** occurs when `i_valid && o_ready`. `o_ready = !full`, computed from registered state, so no push is accepted in a full cycle even if a pop happens in the same cycle.
- **FSM `IDLE`:** if the FIFO is non-empty and `i_mult_ready`, pop the head into the operand registers and go to `ISSUE`; otherwise stay in `IDLE`.
- **FSM `ISSUE`:** `o_mult_start=1` for exactly this cycle; go to `WAIT_BUSY`.
- **FSM `WAIT_BUSY`:** one cycle only. Multiplier contract: Ready is low in this cycle. Go to `WAIT_DONE`.
- **FSM `WAIT_DONE`:** wait for `i_mult_ready=1`.
  - Then `acc_next = acc + sext(i_mult_product)`.
  - If the popped pair had `last` set: register `o_acc=acc_next`, pulse `o_acc_valid`, clear `acc`.
  - Otherwise `acc=acc_next`.
  - Go to `IDLE`.
- **FSM `DRAIN`:** pop one FIFO entry per cycle while non-empty, without issuing; go to `IDLE` after popping an entry with `last` set.
- `o_mult_word1/2` are driven from the operand registers and stay stable from `ISSUE` until `WAIT_DONE` exits.
- **Error:** `i_mult_err` high in `WAIT_BUSY` or `WAIT_DONE` causes:
  - one-cycle `o_err` pulse;
  - `acc` cleared and the current product discarded;
  - if the current pair was `last`, go to `IDLE`, else go to `DRAIN`.
  - No `o_acc_valid` is generated for the faulted vector.
- **Arithmetic:** two's complement. Products are sign-extended from `2*L_word` to `L_ACC`. Without saturation, the sum wraps modulo 2^`L_ACC`.

## Timing
- **Reset values:**
  - `o_ready=1`, `o_mult_start=0`, `o_acc=0`, `o_acc_valid=0`, `o_err=0`, `o_sat=0`;
  - operand words 0, FIFO empty, `acc=0`, state `IDLE`.
- Reset mid-operation discards FIFO contents and the partial sum. The multiplier is reset by the same `i_rst_n`.
- Pushed pair to `o_mult_start`: 2 cycles minimum (push, FIFO visible, pop in `IDLE`, then `ISSUE`).
- Per pair: `ISSUE` + `WAIT_BUSY` + multiplier latency + 1 `IDLE` cycle.
- `o_acc_valid` asserts the cycle after `WAIT_DONE` observes Ready for a `last` pair, and is never high two consecutive cycles.
- **Empty FIFO:** stays in `IDLE` and `o_mult_start` stays 0.
- **Full FIFO:** `o_ready=0`; upstream holds its data.

## Configuration
- **`BOOTH_MAC_SAT_EN` defined:**
  - the accumulate saturates to +2^(`L_ACC`-1)-1 or -2^(`L_ACC`-1);
  - a sticky per-vector flag records any clamp and is output on `o_sat` with `o_acc_valid`;
  - the flag clears with `acc`.
- **Not defined:** wrap-around arithmetic; `o_sat` tied to 0.

## Structure
- **Package `booth_mac_pkg`:**
  - FSM state enum (`IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`, `DRAIN`);
  - `L_ACC` computation function;
  - FIFO entry struct {a, b, last}.
- **Sub-module `booth_op_fifo`:** synchronous FIFO with parameter `L_DEPTH`, ports push/pop/full/empty, and head data visible combinationally.

## Test plan
- `L_word=4`; push (3,2), (-1,5), (7,7, last) → three start pulses; `o_acc=50`, one `o_acc_valid` pulse.
- Push 5 pairs back-to-back with `L_DEPTH=4` while the multiplier is stalled → `o_ready` drops after the 4th push; the 5th pair is held and accepted after the first pop.
- Inject `i_mult_err` on the 2nd of pairs (1,1), (2,2), (3,3, last), then a vector (2,3, last) → `o_err` pulses once; the remaining pair is drained unissued; the next result is `o_acc=6`.
- `L_GUARD=0`; 2 × (-8,-8) products of 64 → with `BOOTH_MAC_SAT_EN`, `o_acc=127` and `o_sat=1`; without it, `o_acc=-128` (wrap) and `o_sat=0`.
- Assert `i_rst_n=0` for one cycle in `WAIT_DONE` with 2 entries queued → all outputs return to reset values, `o_ready=1`, and no `o_acc_valid` follows.
- Single pair (-8,7, last) → `o_acc=-56`, sign-extended to `L_ACC` bits.

Source files
------------

// File: rtl/booth_mac_pkg.sv
// booth_mac_pkg: shared types for the Booth MAC sequencer.
//   state_e      - sequencer FSM states
//   fifo_entry_t - one queued operand pair {a, b, last}
//   acc_width()  - accumulator width from operand width and guard bits
// L_WORD is the operand width the entry struct is built with; the top's
// L_word parameter defaults to it and must stay equal to it.
package booth_mac_pkg;

  localparam int L_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [L_WORD-1:0] a;
    logic [L_WORD-1:0] b;
    logic              last;
  } fifo_entry_t;

  function automatic int acc_width(input int l_word, input int l_guard);
    return 2 * l_word + l_guard;
  endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// booth_op_fifo: synchronous FIFO for operand pairs.
// Ports: clk_i, rst_ni (sync, active-low), push_i/din_i, pop_i, head_o
// (combinational view of the oldest entry), full_o, empty_o.
// Pushes while full and pops while empty are ignored.
module booth_op_fifo #(
  parameter type T       = logic,
  parameter int  L_DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(L_DEPTH);

  T               mem_q [L_DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q;
  logic           do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(L_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/booth_mac_sequencer.sv
// booth_mac_sequencer: MAC front/back end around a radix-2 Booth multiplier.
// Operand pairs enter through i_a/i_b/i_last with i_valid/o_ready into a
// FIFO; one multiply at a time is issued over o_mult_start/i_mult_ready and
// each product is sign-extended into the accumulator. A pair tagged last
// closes the vector: o_acc is loaded and o_acc_valid pulses for one cycle.
// i_mult_err aborts the vector (o_err pulse, remaining pairs drained).
// Ports: i_clk, i_rst_n (sync, active-low), operand stream, multiplier
// handshake (o_mult_word1/2, o_mult_start, i_mult_product, i_mult_ready,
// i_mult_err), result (o_acc, o_acc_valid, o_sat), o_err.
// Build option: BOOTH_MAC_SAT_EN - saturating accumulate with a sticky
// per-vector clamp flag on o_sat; otherwise the sum wraps and o_sat is 0.
module booth_mac_sequencer
  import booth_mac_pkg::*;
#(
  parameter  int L_word  = L_WORD,
  parameter  int L_DEPTH = 4,
  parameter  int L_GUARD = 4,
  localparam int L_ACC   = acc_width(L_word, L_GUARD)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [L_word-1:0]   i_a,
  input  logic [L_word-1:0]   i_b,
  input  logic                i_last,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [L_word-1:0]   o_mult_word1,
  output logic [L_word-1:0]   o_mult_word2,
  output logic                o_mult_start,
  input  logic [2*L_word-1:0] i_mult_product,
  input  logic                i_mult_ready,
  input  logic                i_mult_err,
  output logic [L_ACC-1:0]    o_acc,
  output logic                o_acc_valid,
  output logic                o_err,
  output logic                o_sat
);

  state_e            state_q;
  logic [L_word-1:0] word1_q, word2_q;
  logic              last_q;
  logic [L_ACC-1:0]  acc_q, acc_d, acc_out_q;
  logic              sat_q, sat_d, sat_out_q, clamp;
  logic              start_q, acc_valid_q, err_q;
  fifo_entry_t       push_e, head_e;
  logic              full, empty, push, pop;

  // Ready comes from registered occupancy only, so a full FIFO refuses a
  // push even in a cycle where it is also popping.
  assign o_ready = !full;
  assign push    = i_valid && !full;
  assign push_e  = '{a: i_a, b: i_b, last: i_last};
  // IDLE pops only when the multiplier can take the pair; DRAIN discards.
  assign pop     = !empty && ((state_q == IDLE && i_mult_ready) || state_q == DRAIN);

  booth_op_fifo #(
    .T       (fifo_entry_t),
    .L_DEPTH (L_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .din_i   (push_e),
    .pop_i   (pop),
    .head_o  (head_e),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef BOOTH_MAC_SAT_EN
  // One extra bit exposes signed overflow: top two bits disagree.
  logic [L_ACC:0] sum_w;
  always_comb begin
    sum_w = {acc_q[L_ACC-1], acc_q} + (L_ACC+1)'($signed(i_mult_product));
    clamp = (sum_w[L_ACC] != sum_w[L_ACC-1]);
    acc_d = sum_w[L_ACC-1:0];
    if (clamp)
      acc_d = sum_w[L_ACC] ? {1'b1, {(L_ACC-1){1'b0}}} : {1'b0, {(L_ACC-1){1'b1}}};
  end
`else
  always_comb begin
    acc_d = acc_q + L_ACC'($signed(i_mult_product));
    clamp = 1'b0;
  end
`endif

  assign sat_d = sat_q | clamp;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      word1_q     <= '0;
      word2_q     <= '0;
      last_q      <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      acc_out_q   <= '0;
      sat_out_q   <= 1'b0;
      start_q     <= 1'b0;
      acc_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      acc_valid_q <= 1'b0;
      err_q       <= 1'b0;
      sat_out_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            word1_q <= head_e.a;
            word2_q <= head_e.b;
            last_q  <= head_e.last;
            start_q <= 1'b1;  // high exactly during ISSUE
            state_q <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT_BUSY;
        WAIT_BUSY, WAIT_DONE: begin
          if (i_mult_err) begin
            err_q   <= 1'b1;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            state_q <= last_q ? IDLE : DRAIN;
          end else if (state_q == WAIT_BUSY) begin
            state_q <= WAIT_DONE;
          end else if (i_mult_ready) begin
            if (last_q) begin
              acc_out_q   <= acc_d;
              sat_out_q   <= sat_d;
              acc_valid_q <= 1'b1;
              acc_q       <= '0;
              sat_q       <= 1'b0;
            end else begin
              acc_q <= acc_d;
              sat_q <= sat_d;
            end
            state_q <= IDLE;
          end
        end
        DRAIN: begin
          if (!empty && head_e.last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_mult_word1 = word1_q;
  assign o_mult_word2 = word2_q;
  assign o_mult_start = start_q;
  assign o_acc        = acc_out_q;
  assign o_acc_valid  = acc_valid_q;
  assign o_err        = err_q;
  assign o_sat        = sat_out_q;

endmodule

// File: tb/tb_booth_mac_sequencer.sv
// Bench for booth_mac_sequencer with L_word=4, L_DEPTH=4, L_GUARD=0
// (8-bit accumulator). A behavioural multiplier answers start pulses after
// a fixed latency; it can be stalled and made to raise an error on a chosen
// issue number.
module tb_booth_mac_sequencer;

  localparam int W   = 4;
  localparam int ACC = 8;
  localparam int LAT = 2;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [W-1:0]   i_a = '0, i_b = '0;
  logic           i_last = 1'b0, i_valid = 1'b0;
  logic           o_ready;
  logic [W-1:0]   o_mult_word1, o_mult_word2;
  logic           o_mult_start;
  logic [2*W-1:0] i_mult_product;
  logic           i_mult_ready, i_mult_err;
  logic [ACC-1:0] o_acc;
  logic           o_acc_valid, o_err, o_sat;

  always #5 i_clk = ~i_clk;

  booth_mac_sequencer #(.L_word(W), .L_DEPTH(4), .L_GUARD(0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_a(i_a), .i_b(i_b), .i_last(i_last),
    .i_valid(i_valid), .o_ready(o_ready), .o_mult_word1(o_mult_word1),
    .o_mult_word2(o_mult_word2), .o_mult_start(o_mult_start),
    .i_mult_product(i_mult_product), .i_mult_ready(i_mult_ready),
    .i_mult_err(i_mult_err), .o_acc(o_acc), .o_acc_valid(o_acc_valid),
    .o_err(o_err), .o_sat(o_sat)
  );

  // Multiplier stand-in
  logic              m_busy;
  int                m_cnt, m_issue_no;
  logic signed [7:0] m_prod;
  logic              stall = 1'b0;
  int                err_issue = 0;

  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_busy <= 1'b0; m_cnt <= 0; m_prod <= '0; m_issue_no <= 0;
    end else if (o_mult_start) begin
      m_busy     <= 1'b1;
      m_cnt      <= LAT;
      m_prod     <= $signed(o_mult_word1) * $signed(o_mult_word2);
      m_issue_no <= m_issue_no + 1;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end
  end

  assign i_mult_ready   = !m_busy && !stall;
  assign i_mult_product = m_prod;
  assign i_mult_err     = (err_issue != 0) && m_busy && (m_issue_no == err_issue);

  // Pulse counters
  int   n_start = 0, n_valid = 0, n_err = 0, n_dbl = 0;
  logic prev_valid = 1'b0;
  always @(negedge i_clk) begin
    if (o_mult_start) n_start <= n_start + 1;
    if (o_acc_valid)  n_valid <= n_valid + 1;
    if (o_err)        n_err   <= n_err + 1;
    if (o_acc_valid && prev_valid) n_dbl <= n_dbl + 1;
    prev_valid <= o_acc_valid;
  end

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    int n = 0;
    i_a = a; i_b = b; i_last = last; i_valid = 1'b1;
    while (!o_ready && n < 100) begin tick(); n++; end
    check("push_ready", 32'(o_ready), 32'd1);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output logic [ACC-1:0] acc, output logic sat);
    int n = 0;
    do begin tick(); n++; end while (!o_acc_valid && n < 200);
    check({name, "_valid"}, 32'(o_acc_valid), 32'd1);
    acc = o_acc;
    sat = o_sat;
    tick();  // let the pulse counters see the strobe
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(o_ready),      32'd1);
    check({tag, "_start"}, 32'(o_mult_start), 32'd0);
    check({tag, "_acc"},   32'(o_acc),        32'd0);
    check({tag, "_valid"}, 32'(o_acc_valid),  32'd0);
    check({tag, "_err"},   32'(o_err),        32'd0);
    check({tag, "_sat"},   32'(o_sat),        32'd0);
    check({tag, "_words"}, 32'({o_mult_word1, o_mult_word2}), 32'd0);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [ACC-1:0] acc;
  } vec_t;

  initial begin
    vec_t           tbl [8];
    logic [ACC-1:0] acc;
    logic           sat;
    int             s0, v0, e0, n;

    tbl[0] = '{4'h8, 4'h7, 8'hC8};  // -8 * 7  = -56
    tbl[1] = '{4'h3, 4'h2, 8'h06};  //  3 * 2  = 6
    tbl[2] = '{4'h7, 4'h7, 8'h31};  //  7 * 7  = 49
    tbl[3] = '{4'hF, 4'h5, 8'hFB};  // -1 * 5  = -5
    tbl[4] = '{4'h0, 4'h7, 8'h00};  //  0 * 7  = 0
    tbl[5] = '{4'h7, 4'h8, 8'hC8};  //  7 * -8 = -56
    tbl[6] = '{4'h8, 4'h8, 8'h40};  // -8 * -8 = 64
    tbl[7] = '{4'hD, 4'hD, 8'h09};  // -3 * -3 = 9

    // Reset state
    tick(); tick();
    check_reset_outputs("rst");
    i_rst_n = 1'b1;
    tick(); tick();
    check("idle_empty_start", 32'(n_start), 32'd0);

    // Single-pair vectors
    foreach (tbl[i]) begin
      s0 = n_start;
      push_pair(tbl[i].a, tbl[i].b, 1'b1);
      wait_result("tbl", acc, sat);
      check($sformatf("tbl%0d_acc", i), 32'(acc), 32'(tbl[i].acc));
      check($sformatf("tbl%0d_sat", i), 32'(sat), 32'd0);
      check($sformatf("tbl%0d_starts", i), 32'(n_start - s0), 32'd1);
    end

    // Three-pair dot product: 6 - 5 + 49 = 50
    s0 = n_start; v0 = n_valid;
    push_pair(4'h3, 4'h2, 1'b0);
    push_pair(4'hF, 4'h5, 1'b0);
    push_pair(4'h7, 4'h7, 1'b1);
    wait_result("dot", acc, sat);
    check("dot_acc", 32'(acc), 32'd50);
    check("dot_starts", 32'(n_start - s0), 32'd3);
    check("dot_valids", 32'(n_valid - v0), 32'd1);

    // Full FIFO with stalled multiplier; 5th pair held until first pop
    s0 = n_start;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_pair(4'h1, 4'h1, 1'b0);
    check("full_ready_low", 32'(o_ready), 32'd0);
    i_a = 4'h1; i_b = 4'h2; i_last = 1'b1; i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_hold", 32'(o_ready), 32'd0);
    end
    check("full_no_issue", 32'(n_start - s0), 32'd0);
    stall = 1'b0;
    push_pair(4'h1, 4'h2, 1'b1);
    wait_result("full", acc, sat);
    check("full_acc", 32'(acc), 32'd6);
    check("full_starts", 32'(n_start - s0), 32'd5);

    // Error on 2nd pair: vector aborted, (3,3) drained, next vector = 6
    s0 = n_start; v0 = n_valid; e0 = n_err;
    err_issue = m_issue_no + 2;
    push_pair(4'h1, 4'h1, 1'b0);
    push_pair(4'h2, 4'h2, 1'b0);
    push_pair(4'h3, 4'h3, 1'b1);
    push_pair(4'h2, 4'h3, 1'b1);
    wait_result("err", acc, sat);
    err_issue = 0;
    check("err_acc", 32'(acc), 32'd6);
    check("err_pulses", 32'(n_err - e0), 32'd1);
    check("err_starts", 32'(n_start - s0), 32'd3);
    check("err_valids", 32'(n_valid - v0), 32'd1);

    // Overflow: 64 + 64 in an 8-bit accumulator
    push_pair(4'h8, 4'h8, 1'b0);
    push_pair(4'h8, 4'h8, 1'b1);
    wait_result("ovf", acc, sat);
`ifdef BOOTH_MAC_SAT_EN
    check("ovf_acc", 32'(acc), 32'h7F);
    check("ovf_sat", 32'(sat), 32'd1);
`else
    check("ovf_acc", 32'(acc), 32'h80);
    check("ovf_sat", 32'(sat), 32'd0);
`endif

    // Reset in WAIT_DONE with two entries still queued
    stall = 1'b1;
    push_pair(4'h1, 4'h1, 1'b0);
    push_pair(4'h2, 4'h2, 1'b0);
    push_pair(4'h3, 4'h3, 1'b1);
    stall = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!o_mult_start && n < 20);
    check("midrst_issue", 32'(o_mult_start), 32'd1);
    tick();  // WAIT_BUSY
    tick();  // WAIT_DONE
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    check_reset_outputs("midrst");
    s0 = n_start; v0 = n_valid;
    for (int i = 0; i < 30; i++) tick();
    check("midrst_no_valid", 32'(n_valid - v0), 32'd0);
    check("midrst_no_start", 32'(n_start - s0), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd1);

    // Recovery after reset
    push_pair(4'h2, 4'h3, 1'b1);
    wait_result("recov", acc, sat);
    check("recov_acc", 32'(acc), 32'd6);

    check("valid_never_back_to_back", 32'(n_dbl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
